// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite definitions for the M0 SoC fabric.
// Contents: HTRANS encodings, default-slave FSM state type, and the
// SoC default slave address map (base/mask) used by the interconnect.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    DS_OK   = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  // Slice i of the packed vectors belongs to slave i (slave 0 in the LSBs).
  localparam int SOC_NSLAVES = 3;
  localparam logic [SOC_NSLAVES*32-1:0] SOC_ADDR_BASE =
    {32'h5000_0000, 32'h4000_0000, 32'h0000_0000};
  localparam logic [SOC_NSLAVES*32-1:0] SOC_ADDR_MASK =
    {SOC_NSLAVES{32'hF000_0000}};

endpackage

// File: rtl/ahb_default_slave.sv
// ahb_default_slave: answers unmapped active transfers with the two-cycle
// AHB ERROR response (ERR1: HREADYOUT=0/HRESP=1, ERR2: HREADYOUT=1/HRESP=1).
// Ports:
//   clk_i        clock
//   srst_i       synchronous active-high reset
//   start_i      an unmapped NONSEQ/SEQ address phase is accepted this cycle
//   hreadyout_o  ready contribution of the default slave
//   hresp_o      response contribution of the default slave (1 = ERROR)
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic clk_i,
  input  logic srst_i,
  input  logic start_i,
  output logic hreadyout_o,
  output logic hresp_o
);

  ds_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      DS_OK:   if (start_i) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      // ERR2 is a ready cycle, so the next address phase is accepted here.
      DS_ERR2: state_d = start_i ? DS_ERR1 : DS_OK;
      default: state_d = DS_OK;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) state_q <= DS_OK;
    else        state_q <= state_d;
  end

  assign hreadyout_o = (state_q != DS_ERR1);
  assign hresp_o     = (state_q != DS_OK);

endmodule

// File: rtl/ahb_multi_interconnect.sv
// ahb_multi_interconnect: single-master AHB-Lite fabric with N slaves.
// Decodes HADDR to a one-hot HSEL (lowest index wins on overlap), registers
// the data-phase target, and muxes HRDATA/HREADY/HRESP back. Unmapped active
// transfers are answered by a built-in default slave, and the first such
// address since the last clear is captured for debug.
// Ports:
//   HCLK, HRESET              clock, synchronous active-high reset
//   HADDR, HTRANS             master address phase
//   HSEL_SIGNALS              one-hot address-phase select (combinational)
//   HRDATA/HREADYOUT/HRESP_SIGNALS  per-slave data-phase returns
//   HRDATA, HREADY, HRESP     muxed data-phase returns to the master
//   ERR_CLEAR, ERR_VALID, ERR_ADDR  sticky unmapped-access capture
module ahb_multi_interconnect
  import ahb_pkg::*;
#(
  parameter int                    NSLAVES   = SOC_NSLAVES,
  parameter logic [NSLAVES*32-1:0] ADDR_BASE = SOC_ADDR_BASE,
  parameter logic [NSLAVES*32-1:0] ADDR_MASK = SOC_ADDR_MASK
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic [31:0]             HADDR,
  input  logic [1:0]              HTRANS,
  output logic [NSLAVES-1:0]      HSEL_SIGNALS,
  input  logic [NSLAVES*32-1:0]   HRDATA_SIGNALS,
  input  logic [NSLAVES-1:0]      HREADYOUT_SIGNALS,
  input  logic [NSLAVES-1:0]      HRESP_SIGNALS,
  output logic [31:0]             HRDATA,
  output logic                    HREADY,
  output logic                    HRESP,
  input  logic                    ERR_CLEAR,
  output logic                    ERR_VALID,
  output logic [31:0]             ERR_ADDR
);

  // Data-phase select codes: 0..NSLAVES-1 real slaves, NSLAVES the default
  // slave, NSLAVES+1 idle (no transfer in data phase).
  localparam logic [4:0] SEL_DEFAULT = 5'(NSLAVES);
  localparam logic [4:0] SEL_IDLE    = 5'(NSLAVES + 1);

  logic [NSLAVES-1:0] match;
  logic [NSLAVES:0]   lower_hit;   // lower_hit[i]: some slave below i matched
  logic [4:0]         hit_idx;
  logic               active;
  logic               err_start;
  logic [4:0]         dp_sel_q, dp_sel_d;
  logic               err_valid_q, err_valid_d;
  logic [31:0]        err_addr_q, err_addr_d;
  logic               ds_ready, ds_resp;

  logic [31:0]        rdata_ext [NSLAVES+1];
  logic [NSLAVES:0]   ready_ext;
  logic [NSLAVES:0]   resp_ext;

  assign lower_hit[0] = 1'b0;

  for (genvar gi = 0; gi < NSLAVES; gi++) begin : gen_slave
    assign match[gi]        = (HADDR & ADDR_MASK[gi*32 +: 32]) == ADDR_BASE[gi*32 +: 32];
    assign lower_hit[gi+1]  = lower_hit[gi] | match[gi];
    assign HSEL_SIGNALS[gi] = match[gi] & ~lower_hit[gi];
    assign rdata_ext[gi]    = HRDATA_SIGNALS[gi*32 +: 32];
    assign ready_ext[gi]    = HREADYOUT_SIGNALS[gi];
    assign resp_ext[gi]     = HRESP_SIGNALS[gi];
  end

  // Default slave occupies the last mux input.
  assign rdata_ext[NSLAVES] = 32'h0;
  assign ready_ext[NSLAVES] = ds_ready;
  assign resp_ext[NSLAVES]  = ds_resp;

  always_comb begin
    hit_idx = SEL_DEFAULT;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if (match[i]) hit_idx = 5'(i);
    end
  end

  assign active    = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
  assign err_start = HREADY & active & ~lower_hit[NSLAVES];

  // Only an accepted address phase moves the data-phase target; a stall
  // keeps it and ignores whatever HADDR does meanwhile.
  always_comb begin
    dp_sel_d = dp_sel_q;
    if (HREADY) dp_sel_d = active ? hit_idx : SEL_IDLE;
  end

  always_comb begin
    HRDATA = 32'h0;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    for (int i = 0; i <= NSLAVES; i++) begin
      if (dp_sel_q == 5'(i)) begin
        HRDATA = rdata_ext[i];
        HREADY = ready_ext[i];
        HRESP  = resp_ext[i];
      end
    end
  end

  // A clear in the same cycle reopens the capture window, so the new
  // address is taken and the flag stays set.
  always_comb begin
    err_valid_d = err_valid_q;
    err_addr_d  = err_addr_q;
    if (ERR_CLEAR) err_valid_d = 1'b0;
    if (err_start && (!err_valid_q || ERR_CLEAR)) begin
      err_valid_d = 1'b1;
      err_addr_d  = HADDR;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_sel_q    <= SEL_IDLE;
      err_valid_q <= 1'b0;
      err_addr_q  <= 32'h0;
    end else begin
      dp_sel_q    <= dp_sel_d;
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
    end
  end

  ahb_default_slave u_default_slave (
    .clk_i       (HCLK),
    .srst_i      (HRESET),
    .start_i     (err_start),
    .hreadyout_o (ds_ready),
    .hresp_o     (ds_resp)
  );

  assign ERR_VALID = err_valid_q;
  assign ERR_ADDR  = err_addr_q;

endmodule

// File: tb/tb_ahb_multi_interconnect.sv
// Bench for ahb_multi_interconnect: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model (data-phase owner + remaining error cycles).
module tb_ahb_multi_interconnect;
  import ahb_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSEL_SIGNALS;
  logic [95:0] HRDATA_SIGNALS;
  logic [2:0]  HREADYOUT_SIGNALS;
  logic [2:0]  HRESP_SIGNALS;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic        ERR_CLEAR;
  logic        ERR_VALID;
  logic [31:0] ERR_ADDR;

  // Second instance: 4 slaves with an overlapping map (slaves 1 and 3).
  logic [31:0]  haddr4;
  logic [3:0]   hsel4;
  logic [127:0] hrdata_sig4 = '0;
  logic [3:0]   hready_sig4 = 4'hF;
  logic [3:0]   hresp_sig4 = 4'h0;
  logic [1:0]   htrans4 = 2'b00;
  logic         clear4 = 1'b0;
  logic [31:0]  hrdata4, err_addr4;
  logic         hready4, hresp4, err_valid4;

  always #5 HCLK = ~HCLK;

  ahb_multi_interconnect dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSEL_SIGNALS(HSEL_SIGNALS), .HRDATA_SIGNALS(HRDATA_SIGNALS),
    .HREADYOUT_SIGNALS(HREADYOUT_SIGNALS), .HRESP_SIGNALS(HRESP_SIGNALS),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .ERR_CLEAR(ERR_CLEAR), .ERR_VALID(ERR_VALID), .ERR_ADDR(ERR_ADDR)
  );

  ahb_multi_interconnect #(
    .NSLAVES(4),
    .ADDR_BASE({32'h4000_0000, 32'h0000_0000, 32'h4000_0000, 32'h1000_0000}),
    .ADDR_MASK({4{32'hF000_0000}})
  ) dut4 (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(haddr4), .HTRANS(htrans4),
    .HSEL_SIGNALS(hsel4), .HRDATA_SIGNALS(hrdata_sig4),
    .HREADYOUT_SIGNALS(hready_sig4), .HRESP_SIGNALS(hresp_sig4),
    .HRDATA(hrdata4), .HREADY(hready4), .HRESP(hresp4),
    .ERR_CLEAR(clear4), .ERR_VALID(err_valid4), .ERR_ADDR(err_addr4)
  );

  int checks = 0;
  int failures = 0;

  // Reference map of the main instance, slave 0 first.
  localparam logic [31:0] MAP_BASE [3] = '{32'h0000_0000, 32'h4000_0000, 32'h5000_0000};

  // Model state: who owns the data phase and how many error cycles remain.
  int          m_kind;      // 0 none, 1 real slave, 2 error response
  int          m_slave;
  int          m_err_left;  // 2 = first error cycle (stall), 1 = last
  bit          m_valid;
  logic [31:0] m_addr;
  bit          model_ok = 0;
  bit          exp_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < 3; i++)
      if ((a & 32'hF000_0000) == MAP_BASE[i]) return i;
    return -1;
  endfunction

  task automatic compare_model();
    logic [31:0] e_rd;
    bit          e_rsp;
    logic [2:0]  e_hsel;
    int          d;
    e_hsel = 3'b000;
    d = ref_decode(HADDR);
    if (d >= 0) e_hsel[d] = 1'b1;
    e_rd = 32'h0; exp_ready = 1'b1; e_rsp = 1'b0;
    if (m_kind == 1) begin
      e_rd      = HRDATA_SIGNALS[m_slave*32 +: 32];
      exp_ready = HREADYOUT_SIGNALS[m_slave];
      e_rsp     = HRESP_SIGNALS[m_slave];
    end else if (m_kind == 2) begin
      exp_ready = (m_err_left == 1);
      e_rsp     = 1'b1;
    end
    if (model_ok) begin
      chk("m_hsel", 32'(HSEL_SIGNALS), 32'(e_hsel));
      chk("m_hrdata", HRDATA, e_rd);
      chk("m_hready", 32'(HREADY), 32'(exp_ready));
      chk("m_hresp", 32'(HRESP), 32'(e_rsp));
      chk("m_err_valid", 32'(ERR_VALID), 32'(m_valid));
      chk("m_err_addr", ERR_ADDR, m_addr);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] t, input bit clr, input bit rst);
    HADDR = a; HTRANS = t; ERR_CLEAR = clr; HRESET = rst;
    #1;
    compare_model();
  endtask

  // Advance the model over the coming clock edge, then the clock itself.
  task automatic tick();
    int d;
    if (HRESET) begin
      m_kind = 0; m_valid = 0; m_addr = 32'h0; model_ok = 1;
    end else begin
      if (ERR_CLEAR) m_valid = 0;
      if (exp_ready) begin
        d = ref_decode(HADDR);
        if (!HTRANS[1]) m_kind = 0;
        else if (d >= 0) begin m_kind = 1; m_slave = d; end
        else begin
          m_kind = 2; m_err_left = 2;
          if (!ERR_VALID || ERR_CLEAR) begin m_valid = 1; m_addr = HADDR; end
        end
      end else if (m_kind == 2) begin
        m_err_left = m_err_left - 1;
      end
    end
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  initial begin
    logic [31:0] a;
    HRESET = 1'b1; HADDR = 32'h0; HTRANS = HTRANS_IDLE; ERR_CLEAR = 1'b0;
    HRDATA_SIGNALS = {32'hCCCC_0002, 32'hBBBB_0001, 32'h1234_5678};
    HREADYOUT_SIGNALS = 3'b111; HRESP_SIGNALS = 3'b000;
    haddr4 = 32'h0;
    @(negedge HCLK);
    drive(32'h0, HTRANS_IDLE, 0, 1); tick();
    drive(32'h0, HTRANS_IDLE, 0, 1); tick();

    // Reset state
    drive(32'h0, HTRANS_IDLE, 0, 0);
    chk("rst_hready", 32'(HREADY), 32'd1);
    chk("rst_hresp", 32'(HRESP), 32'd0);
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_err_valid", 32'(ERR_VALID), 32'd0);
    chk("rst_err_addr", ERR_ADDR, 32'h0);
    tick();

    // Overlapping 4-slave map: lowest index wins
    haddr4 = 32'h4000_0000; #1 chk("ovl_4000", 32'(hsel4), 32'b0010);
    haddr4 = 32'h1000_0004; #1 chk("ovl_1000", 32'(hsel4), 32'b0001);
    haddr4 = 32'h0000_0010; #1 chk("ovl_0000", 32'(hsel4), 32'b0100);
    haddr4 = 32'h8000_0000; #1 chk("ovl_unmap", 32'(hsel4), 32'b0000);
    @(negedge HCLK);

    // Simple read from slave 0
    drive(32'h0000_0010, HTRANS_NONSEQ, 0, 0);
    chk("rd0_hsel", 32'(HSEL_SIGNALS), 32'b001);
    tick();
    drive(32'h0, HTRANS_IDLE, 0, 0);
    chk("rd0_hrdata", HRDATA, 32'h1234_5678);
    chk("rd0_hready", 32'(HREADY), 32'd1);
    tick();

    // Slave 1 stall of 3 cycles; HADDR wanders to an unmapped address meanwhile
    drive(32'h4000_0004, HTRANS_NONSEQ, 0, 0);
    chk("st_hsel", 32'(HSEL_SIGNALS), 32'b010);
    tick();
    HREADYOUT_SIGNALS[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h9000_0000, HTRANS_NONSEQ, 0, 0);
      chk("st_hready_low", 32'(HREADY), 32'd0);
      tick();
    end
    HREADYOUT_SIGNALS[1] = 1'b1;
    drive(32'h0, HTRANS_IDLE, 0, 0);
    chk("st_hrdata", HRDATA, 32'hBBBB_0001);
    chk("st_hready_hi", 32'(HREADY), 32'd1);
    tick();
    drive(32'h0, HTRANS_IDLE, 0, 0);
    chk("st_no_err", 32'(ERR_VALID), 32'd0);
    tick();

    // Unmapped access and back-to-back error pairs
    drive(32'h9000_0000, HTRANS_NONSEQ, 0, 0);
    chk("um_hsel", 32'(HSEL_SIGNALS), 32'b000);
    tick();
    drive(32'h0, HTRANS_IDLE, 0, 0);
    chk("err1_hready", 32'(HREADY), 32'd0);
    chk("err1_hresp", 32'(HRESP), 32'd1);
    tick();
    drive(32'hA000_0000, HTRANS_NONSEQ, 0, 0);
    chk("err2_hready", 32'(HREADY), 32'd1);
    chk("err2_hresp", 32'(HRESP), 32'd1);
    chk("cap_valid", 32'(ERR_VALID), 32'd1);
    chk("cap_addr", ERR_ADDR, 32'h9000_0000);
    tick();
    drive(32'h0, HTRANS_IDLE, 0, 0);
    chk("b2b_err1_hready", 32'(HREADY), 32'd0);
    chk("b2b_err1_hresp", 32'(HRESP), 32'd1);
    tick();
    drive(32'hB000_0000, HTRANS_NONSEQ, 1, 0);
    chk("b2b_err2_hready", 32'(HREADY), 32'd1);
    chk("sticky_addr", ERR_ADDR, 32'h9000_0000);
    tick();
    // Now in ERR1 again; assert reset here
    drive(32'h0, HTRANS_IDLE, 0, 1);
    chk("clrcap_hready", 32'(HREADY), 32'd0);
    chk("clrcap_valid", 32'(ERR_VALID), 32'd1);
    chk("clrcap_addr", ERR_ADDR, 32'hB000_0000);
    tick();
    drive(32'h0, HTRANS_IDLE, 0, 0);
    chk("rst_err1_hready", 32'(HREADY), 32'd1);
    chk("rst_err1_hresp", 32'(HRESP), 32'd0);
    chk("rst_err1_valid", 32'(ERR_VALID), 32'd0);
    tick();

    // IDLE and BUSY to unmapped addresses give no error
    drive(32'hC000_0000, HTRANS_IDLE, 0, 0); tick();
    drive(32'hD000_0000, HTRANS_BUSY, 0, 0); tick();
    drive(32'h0, HTRANS_IDLE, 0, 0);
    chk("idle_um_hready", 32'(HREADY), 32'd1);
    chk("idle_um_hresp", 32'(HRESP), 32'd0);
    chk("idle_um_valid", 32'(ERR_VALID), 32'd0);
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      HRDATA_SIGNALS    = {$urandom, $urandom, $urandom};
      HREADYOUT_SIGNALS = 3'($urandom) | 3'($urandom);
      HRESP_SIGNALS     = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b000;
      a = $urandom;
      case ($urandom_range(0, 5))
        0: a[31:28] = 4'h0;
        1: a[31:28] = 4'h4;
        2: a[31:28] = 4'h5;
        3: a[31:28] = 4'h9;
        default: ;
      endcase
      drive(a, 2'($urandom), ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_multi_interconnect.md
# ahb_multi_interconnect

Parametrised AHB-Lite interconnect for the M0 SoC: the single-master fabric between CORTEXM0DS and N memory-mapped slaves. It decodes HADDR against a per-slave base/mask map and drives one-hot HSEL. It registers the data-phase selection and multiplexes HRDATA, HREADY and HRESP back to the master. Unlike the fixed three-slave decoder, it has a configurable slave count and map, slave HRESP pass-through, a built-in default slave giving the two-cycle AHB ERROR response on unmapped accesses, and a sticky error-address capture register for debug.

## Interface
- NSLAVES, 3, number of slaves (1..16)
- ADDR_BASE, {32'h5000_0000, 32'h4000_0000, 32'h0000_0000}, packed NSLAVES×32 base addresses; slice i is slave i
- ADDR_MASK, {3{32'hF000_0000}}, packed NSLAVES×32 masks; slave i matches when (HADDR & MASK_i) == BASE_i
- HCLK  input  1  system clock; all state updates on rising edge
- HRESET  input  1  synchronous, active-high reset; sampled on HCLK rising edge
- HADDR  input  32  master address
- HTRANS  input  2  master transfer type
- HSEL_SIGNALS  output  NSLAVES  one-hot address-phase slave select
- HRDATA_SIGNALS  input  NSLAVES×32  slave read data; slice i is slave i
- HREADYOUT_SIGNALS  input  NSLAVES  slave ready outputs
- HRESP_SIGNALS  input  NSLAVES  slave response (1 = ERROR)
- HRDATA  output  32  muxed read data to master and slaves
- HREADY  output  1  muxed ready to master and slaves
- HRESP  output  1  muxed response to master
- ERR_CLEAR  input  1  clears ERR_VALID
- ERR_VALID  output  1  sticky flag: an unmapped transfer has occurred
- ERR_ADDR  output  32  HADDR of first unmapped transfer since the last clear

## Operation
- Decode is combinational from HADDR only. When several slaves match, the lowest index wins. At most one HSEL bit is high; all are zero if unmapped. HSEL does not depend on HTRANS, because slaves qualify with HTRANS and HREADY.
- Address phase is accepted when HREADY=1. The data-phase select register updates only then:
  - HTRANS[1]=0 (IDLE/BUSY) → IDLE_DP.
  - Matched → SLAVE(i).
  - Unmapped with HTRANS[1]=1 → DEFAULT.
- Data-phase output mux:
  - IDLE_DP: HRDATA=0, HREADY=1, HRESP=0.
  - SLAVE(i): HRDATA, HREADY and HRESP pass through from slave i.
  - DEFAULT: driven by the default-slave FSM.
- Default-slave FSM has states OK, ERR1, ERR2:
  - OK → ERR1 when an unmapped NONSEQ/SEQ is accepted.
  - ERR1 drives HREADY=0, HRESP=1, then always moves to ERR2.
  - ERR2 drives HREADY=1, HRESP=1. Its exit depends on the next address phase, which is accepted in that cycle: another unmapped NONSEQ/SEQ goes to ERR1; anything else goes to OK.
  - HRDATA=0 throughout.
- Error capture: when an unmapped NONSEQ/SEQ is accepted and ERR_VALID=0, ERR_ADDR<=HADDR and ERR_VALID<=1. Later errors do not overwrite ERR_ADDR.
- ERR_CLEAR=1 sets ERR_VALID<=0. If a capture happens in the same cycle, capture wins: ERR_VALID stays 1 and ERR_ADDR is updated.

## Timing
- Reset values: data-phase select = IDLE_DP, FSM = OK, HREADY=1, HRESP=0, HRDATA=0, ERR_VALID=0, ERR_ADDR=0. HSEL_SIGNALS stays combinational from HADDR.
- Reset asserted mid-transfer, including during ERR1: all state returns to reset values on that edge. HREADY=1 and HRESP=0 from the next cycle.
- Latency: HSEL has zero latency. Data-phase select is one cycle after acceptance. The mux is combinational from slave inputs in the same cycle.
- An unmapped access costs exactly 2 data-phase cycles (ERR1, ERR2).
- Back-to-back unmapped accesses repeat the ERR1/ERR2 pair with no OK cycle in between.
- A slave stall (HREADYOUT=0) holds the data-phase select, and HADDR is not re-decoded until HREADY=1.

## Structure
- Shared package ahb_pkg holds:
  - HTRANS constants (IDLE, BUSY, NONSEQ, SEQ);
  - the default-slave state enum (OK, ERR1, ERR2);
  - the SoC default address map constants used for ADDR_BASE/ADDR_MASK.
- Sub-module ahb_default_slave contains the OK/ERR1/ERR2 FSM and drives its own HREADYOUT/HRESP. The interconnect treats it as mux input NSLAVES.
- Decode and mux are generate loops over NSLAVES.

## Test plan
- Reset, then NONSEQ read 0x0000_0010 with slave0 HRDATA=0x1234_5678 → HSEL_SIGNALS=3'b001; next cycle HRDATA=0x1234_5678, HREADY=1.
- NONSEQ at 0x4000_0004 with slave1 HREADYOUT low for 3 cycles → HREADY=0 for 3 cycles; HADDR change during the stall does not alter the data-phase select.
- NONSEQ at 0x9000_0000 → HSEL=0; next cycle HREADY=0/HRESP=1; then HREADY=1/HRESP=1; ERR_VALID=1; ERR_ADDR=0x9000_0000.
- Second unmapped access at 0xA000_0000 in the ERR2 cycle → ERR1/ERR2 repeat; ERR_ADDR stays 0x9000_0000. ERR_CLEAR pulsed in the same cycle as an unmapped capture of 0xB000_0000 → ERR_VALID stays 1 and ERR_ADDR=0xB000_0000.
- HRESET asserted during ERR1 → next cycle HREADY=1, HRESP=0, ERR_VALID=0.
- NSLAVES=4 with an overlapping map, slaves 1 and 3 both matching 0x4000_0000 → HSEL=4'b0010. IDLE transfer to an unmapped address → no error response and ERR_VALID unchanged.
